// File: rtl/sync_pkg.sv
// Shared VGA timing definitions: tracker states, counter width and the
// 640x480@60 nominal timing used by both sync_generator and sync_decoder.
package sync_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    localparam int CW_DEFAULT  = 11;
    localparam int SAT_DEFAULT = (1 << CW_DEFAULT) - 1;

    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;
    localparam int H_PULSE = 96;
    localparam int V_PULSE = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus history flop for one sync input; reports the
// synced active level and single-cycle leading/trailing edge strobes.
module sync_edge_detect #(
    parameter logic ACTIVE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic clr_n,
    input  logic sync_raw,
    output logic active,
    output logic lead,
    output logic trail
);

    logic meta;
    logic synced;
    logic hist;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            meta   <= ~ACTIVE_LEVEL;
            synced <= ~ACTIVE_LEVEL;
            hist   <= ~ACTIVE_LEVEL;
        end else begin
            meta   <= sync_raw;
            synced <= meta;
            hist   <= synced;
        end
    end

    assign active = (synced == ACTIVE_LEVEL);
    assign lead   = active && (hist != ACTIVE_LEVEL);
    assign trail  = !active && (hist == ACTIVE_LEVEL);

endmodule

// File: rtl/sync_decoder.sv
// VGA sync receiver: regenerates hc/vc from incoming syncs, measures line,
// frame and pulse timing, and tracks lock against a learned reference.
module sync_decoder
    import sync_pkg::*;
#(
    parameter logic HSYNC_ON    = 1'b0,
    parameter logic VSYNC_ON    = 1'b0,
    parameter int   CW          = CW_DEFAULT,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic          px_clk,
    input  logic          clr_n,
    input  logic          hsync_in,
    input  logic          vsync_in,
    output logic [CW-1:0] hc,
    output logic [CW-1:0] vc,
    output logic [CW-1:0] line_len,
    output logic [CW-1:0] frame_lines,
    output logic [CW-1:0] hpulse_len,
    output logic [CW-1:0] vpulse_lines,
    output logic          locked,
    output logic          timing_err
);

    localparam logic [CW-1:0] SAT    = '1;
    localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FRAMES);

    logic h_act, h_lead, h_trail;
    logic v_act, v_lead, v_trail;

    sync_edge_detect #(.ACTIVE_LEVEL(HSYNC_ON)) u_hsync (
        .clk(px_clk), .clr_n(clr_n), .sync_raw(hsync_in),
        .active(h_act), .lead(h_lead), .trail(h_trail)
    );

    sync_edge_detect #(.ACTIVE_LEVEL(VSYNC_ON)) u_vsync (
        .clk(px_clk), .clr_n(clr_n), .sync_raw(vsync_in),
        .active(v_act), .lead(v_lead), .trail(v_trail)
    );

    sync_state_t   state, state_next;
    logic [CW-1:0] hpulse_cnt, vpulse_cnt, good, good_next, good_inc;
    logic [CW-1:0] meas_line, meas_frame;
    logic          vpend, frame_bad;
    logic          frame_start, sat_evt, learn_line, line_bad, frame_ok;
    logic          err_next, set_lock, clr_lock, track_enter, lose_lock;

    // A vlead coinciding with an hlead starts the frame on that same hlead.
    assign frame_start = h_lead && (vpend || v_lead);
    assign meas_line   = (hc == SAT) ? SAT : hc + 1'b1;
    assign meas_frame  = (vc == SAT) ? SAT : vc + 1'b1;
    assign sat_evt     = (!h_lead && hc == SAT - 1'b1) ||
                         (h_lead && !frame_start && vc == SAT - 1'b1);
    assign learn_line  = (state == TRACK) && h_lead && !frame_start &&
                         (vc == '0) && (line_len == '0);
    assign line_bad    = h_lead && !frame_start && (line_len != '0) &&
                         (meas_line != line_len);
    assign frame_ok    = !frame_bad && (meas_frame == frame_lines);
    assign good_inc    = good + 1'b1;

    always_ff @(posedge px_clk or negedge clr_n) begin
        if (!clr_n) state <= SEARCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        err_next    = 1'b0;
        set_lock    = 1'b0;
        clr_lock    = 1'b0;
        track_enter = 1'b0;
        lose_lock   = 1'b0;
        good_next   = good;
        if (sat_evt) begin
            state_next = SEARCH;
            err_next   = (state != SEARCH);
            clr_lock   = 1'b1;
            good_next  = '0;
        end else begin
            case (state)
                SEARCH: if (frame_start) begin
                    state_next  = TRACK;
                    track_enter = 1'b1;
                    good_next   = '0;
                end
                TRACK: if (frame_start) begin
                    good_next = frame_ok ? good_inc : '0;
                    if (frame_ok && good_inc >= LOCK_N) begin
                        state_next = LOCKED;
                        set_lock   = 1'b1;
                    end
                end
                LOCKED: if (line_bad || (frame_start && !frame_ok)) begin
                    state_next = TRACK;
                    err_next   = 1'b1;
                    clr_lock   = 1'b1;
                    lose_lock  = 1'b1;
                    good_next  = '0;
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    always_ff @(posedge px_clk or negedge clr_n) begin
        if (!clr_n) begin
            hc           <= '0;
            vc           <= '0;
            line_len     <= '0;
            frame_lines  <= '0;
            hpulse_len   <= '0;
            vpulse_lines <= '0;
            locked       <= 1'b0;
            timing_err   <= 1'b0;
            hpulse_cnt   <= '0;
            vpulse_cnt   <= '0;
            good         <= '0;
            vpend        <= 1'b0;
            frame_bad    <= 1'b0;
        end else begin
            timing_err <= err_next;
            good       <= good_next;
            if (set_lock)      locked <= 1'b1;
            else if (clr_lock) locked <= 1'b0;

            if (h_lead)         hc <= '0;
            else if (hc != SAT) hc <= hc + 1'b1;

            if (frame_start) begin
                vc    <= '0;
                vpend <= 1'b0;
            end else begin
                if (v_lead)                vpend <= 1'b1;
                if (h_lead && (vc != SAT)) vc    <= vc + 1'b1;
            end

            if (!h_act)                 hpulse_cnt <= '0;
            else if (hpulse_cnt != SAT) hpulse_cnt <= hpulse_cnt + 1'b1;
            if (h_trail) hpulse_len <= hpulse_cnt;

            if (!v_act)                            vpulse_cnt <= '0;
            else if (h_lead && (vpulse_cnt != SAT)) vpulse_cnt <= vpulse_cnt + 1'b1;
            if (v_trail) vpulse_lines <= vpulse_cnt;

            // Line reference is re-learned from the first complete line of a frame.
            if (track_enter || lose_lock) line_len <= '0;
            else if (learn_line)          line_len <= meas_line;

            if (track_enter || (frame_start && state != SEARCH)) frame_bad <= 1'b0;
            else if (line_bad)                                   frame_bad <= 1'b1;

            if (frame_start && state != SEARCH) frame_lines <= meas_frame;
        end
    end

endmodule

// File: tb/tb_sync_decoder.sv
// Directed bench for sync_decoder: lock/error events go through an expected
// queue checked by a monitor; measurements are checked against fixed values.
module tb_sync_decoder;
    import sync_pkg::*;

    localparam int  W      = CW_DEFAULT;
    localparam logic HON   = 1'b0;
    localparam logic VON   = 1'b0;
    localparam int  SM_LEN = 40;
    localparam int  SM_LN  = 12;
    localparam int  SM_HP  = 6;
    localparam int  SM_VP  = 2;
    localparam int  BG_LN  = 5;
    localparam logic [2:0] EV_NONE = 3'b000;
    localparam logic [2:0] EV_ERR  = 3'b001;
    localparam logic [2:0] EV_RISE = 3'b010;
    localparam logic [2:0] EV_FALL = 3'b100;

    logic         px_clk = 1'b0;
    logic         clr_n;
    logic         hsync_in, vsync_in;
    logic [W-1:0] hc, vc, line_len, frame_lines, hpulse_len, vpulse_lines;
    logic         locked, timing_err;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_line_cyc = 0;
    logic mon_en = 1'b0;
    logic prev_locked = 1'b0;
    logic [31:0] exp_q[$];

    sync_decoder #(
        .HSYNC_ON(HON), .VSYNC_ON(VON), .CW(W), .LOCK_FRAMES(2)
    ) dut (
        .px_clk(px_clk), .clr_n(clr_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hc(hc), .vc(vc), .line_len(line_len), .frame_lines(frame_lines),
        .hpulse_len(hpulse_len), .vpulse_lines(vpulse_lines),
        .locked(locked), .timing_err(timing_err)
    );

    // clock / cycle counter
    always #5 px_clk = ~px_clk;
    always @(posedge px_clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // kind 1 = timing_err, 2 = locked rise, 3 = locked fall
    task automatic push_events(input logic [2:0] ev, input int t);
        logic [29:0] tt;
        tt = 30'(t);
        if (ev[0]) exp_q.push_back({2'd1, tt});
        if (ev[1]) exp_q.push_back({2'd2, tt});
        if (ev[2]) exp_q.push_back({2'd3, tt});
    endtask

    task automatic mon_event(input logic [1:0] kind);
        logic [31:0] act, exp;
        logic [29:0] tt;
        tt  = 30'(cyc);
        act = {kind, tt};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            exp = exp_q.pop_front();
            if (act != exp) begin
                errors++;
                $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                         kind, cyc, exp[31:30], exp[29:0]);
            end
        end
    endtask

    // monitor
    always @(negedge px_clk) begin
        if (mon_en) begin
            if (timing_err)              mon_event(2'd1);
            if (locked && !prev_locked)  mon_event(2'd2);
            if (!locked && prev_locked)  mon_event(2'd3);
        end
        prev_locked = locked;
    end

    // drivers: pins change 1 time unit after the edge that sets cyc
    task automatic drive_line(input int len, input int hp, input bit vact, input logic [2:0] ev);
        for (int x = 0; x < len; x++) begin
            @(posedge px_clk); #1;
            hsync_in = (x < hp) ? HON : ~HON;
            vsync_in = vact ? VON : ~VON;
            if (x == 0) begin
                last_line_cyc = cyc;
                push_events(ev, cyc + 3);
            end
        end
    endtask

    task automatic drive_frame(input int len, input int lines, input int hp, input int vp,
                               input int bad_y, input logic [2:0] start_ev, input logic [2:0] bad_ev);
        for (int y = 0; y < lines; y++) begin
            drive_line((y == bad_y) ? len - 1 : len, hp, (y < vp),
                       (y == 0) ? start_ev : ((y == bad_y + 1) ? bad_ev : EV_NONE));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge px_clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, " hc"}, hc, 0);
        check_val({tag, " vc"}, vc, 0);
        check_val({tag, " line_len"}, line_len, 0);
        check_val({tag, " frame_lines"}, frame_lines, 0);
        check_val({tag, " hpulse_len"}, hpulse_len, 0);
        check_val({tag, " vpulse_lines"}, vpulse_lines, 0);
        check_val({tag, " locked"}, locked, 0);
        check_val({tag, " timing_err"}, timing_err, 0);
    endtask

    initial begin
        clr_n    = 1'b0;
        hsync_in = ~HON;
        vsync_in = ~VON;
        idle(3);
        check_zero_outputs("reset");
        clr_n  = 1'b1;
        mon_en = 1'b1;

        // idle syncs: hc saturates silently in SEARCH
        idle(2100);
        check_val("idle hc", hc, SAT_DEFAULT);
        check_val("idle vc", vc, 0);
        check_val("idle locked", locked, 0);

        // nominal 800-clock lines, short frames to bound run time
        for (int f = 0; f < 3; f++)
            drive_frame(H_TOTAL, BG_LN, H_PULSE, V_PULSE, -1, EV_NONE, EV_NONE);
        drive_frame(H_TOTAL, BG_LN, H_PULSE, V_PULSE, -1, EV_RISE, EV_NONE);
        check_val("nom line_len", line_len, H_TOTAL);
        check_val("nom frame_lines", frame_lines, BG_LN);
        check_val("nom hpulse_len", hpulse_len, H_PULSE);
        check_val("nom vpulse_lines", vpulse_lines, V_PULSE);
        check_val("nom locked", locked, 1);

        // async reset mid-line while locked
        drive_line(100, H_PULSE, 1'b0, EV_NONE);
        clr_n = 1'b0;
        push_events(EV_FALL, cyc);
        #1;
        check_zero_outputs("midline reset");
        idle(4);
        clr_n = 1'b1;

        // small timing: relock needs the full count again
        for (int f = 0; f < 3; f++)
            drive_frame(SM_LEN, SM_LN, SM_HP, SM_VP, -1, EV_NONE, EV_NONE);
        drive_frame(SM_LEN, SM_LN, SM_HP, SM_VP, -1, EV_RISE, EV_NONE);
        check_val("small line_len", line_len, SM_LEN);
        check_val("small frame_lines", frame_lines, SM_LN);
        check_val("small hpulse_len", hpulse_len, SM_HP);
        check_val("small vpulse_lines", vpulse_lines, SM_VP);

        // one short line while locked
        drive_frame(SM_LEN, SM_LN, SM_HP, SM_VP, 5, EV_NONE, EV_ERR | EV_FALL);
        check_val("short line locked", locked, 0);
        drive_frame(SM_LEN, SM_LN, SM_HP, SM_VP, -1, EV_NONE, EV_NONE);
        drive_frame(SM_LEN, SM_LN, SM_HP, SM_VP, -1, EV_NONE, EV_NONE);
        drive_frame(SM_LEN, SM_LN, SM_HP, SM_VP, -1, EV_RISE, EV_NONE);
        check_val("relearned line_len", line_len, SM_LEN);

        // one short frame while locked
        drive_frame(SM_LEN, SM_LN - 1, SM_HP, SM_VP, -1, EV_NONE, EV_NONE);
        drive_frame(SM_LEN, SM_LN, SM_HP, SM_VP, -1, EV_ERR | EV_FALL, EV_NONE);
        check_val("short frame frame_lines", frame_lines, SM_LN - 1);
        check_val("short frame locked", locked, 0);
        drive_frame(SM_LEN, SM_LN, SM_HP, SM_VP, -1, EV_NONE, EV_NONE);
        drive_frame(SM_LEN, SM_LN, SM_HP, SM_VP, -1, EV_NONE, EV_NONE);
        drive_frame(SM_LEN, SM_LN, SM_HP, SM_VP, -1, EV_RISE, EV_NONE);
        check_val("restored frame_lines", frame_lines, SM_LN);

        // hsync stops mid-frame: hc saturates 2050 clocks after the last pin lead
        drive_frame(SM_LEN, 5, SM_HP, SM_VP, -1, EV_NONE, EV_NONE);
        push_events(EV_ERR | EV_FALL, last_line_cyc + 2050);
        idle(2100);
        check_val("stopped locked", locked, 0);
        check_val("stopped hc", hc, SAT_DEFAULT);
        drive_frame(SM_LEN, SM_LN, SM_HP, SM_VP, -1, EV_NONE, EV_NONE);
        drive_frame(SM_LEN, SM_LN, SM_HP, SM_VP, -1, EV_NONE, EV_NONE);
        drive_frame(SM_LEN, SM_LN, SM_HP, SM_VP, -1, EV_RISE, EV_NONE);
        check_val("restart locked", locked, 1);

        idle(10);
        while (exp_q.size() != 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL event: got nothing, expected kind %0d at cycle %0d", e[31:30], e[29:0]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
